pattern_match_engine: RTL and testbench

- Registered, parametrised multi-pattern word detector for the adder/display datapath.
- Compares each valid input word against NUM_PAT programmable pattern slots. Each slot has a per-bit care mask and its own enable.
- Supports an N-consecutive-hit qualifier, a sticky Set flag and a saturating hit counter.
- Replaces hard-wired combinational match equations; matches are runtime-programmable.

---
 rtl/pattern_match_engine.sv | 153 +++++++++++++++
 tb/tb_pattern_match_engine.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_match_engine.sv
// rtl/pattern_match_engine.sv - programmable multi-slot word detector with run qualifier
module pattern_match_engine #(
   parameter int WIDTH   = 19,
   parameter int NUM_PAT = 2,
   parameter int CNT_W   = 8,
   parameter int REQ_W   = 4,
   localparam int IDX_W  = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [IDX_W-1:0] cfg_idx,
   input  logic [WIDTH-1:0] cfg_pattern,
   input  logic [WIDTH-1:0] cfg_care,
   input  logic             cfg_en,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_word,
   input  logic [REQ_W-1:0] req_consec,
   input  logic             clr,
   output logic             match,
   output logic [IDX_W-1:0] match_idx,
   output logic             set,
   output logic [CNT_W-1:0] hit_count,
   output logic [1:0]       run_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      LOCK = 2'd2
   } state_t;

   logic [WIDTH-1:0] pat_q  [NUM_PAT];
   logic [WIDTH-1:0] care_q [NUM_PAT];
   logic [NUM_PAT-1:0] en_q;

   logic             any_hit;
   logic [IDX_W-1:0] hit_idx;
   logic [REQ_W-1:0] req;
   logic [REQ_W-1:0] run_q;
   logic [REQ_W-1:0] run_d;
   logic             fire;
   state_t           state_q;
   state_t           state_d;

   // Slot table: a write only lands on an in-range index; comparisons this cycle see the old contents
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NUM_PAT; k++) begin
            pat_q[k]  <= '0;
            care_q[k] <= '0;
         end
         en_q <= '0;
      end else begin
         for (int k = 0; k < NUM_PAT; k++) begin
            if (cfg_we && (cfg_idx == IDX_W'(k))) begin
               pat_q[k]  <= cfg_pattern;
               care_q[k] <= cfg_care;
               en_q[k]   <= cfg_en;
            end
         end
      end
   end

   // Per-slot compare; scanning downward leaves the lowest hitting slot as the winner
   always_comb begin
      any_hit = 1'b0;
      hit_idx = '0;
      for (int k = NUM_PAT - 1; k >= 0; k--) begin
         if (en_q[k] && (((in_word ^ pat_q[k]) & care_q[k]) == '0)) begin
            any_hit = 1'b1;
            hit_idx = IDX_W'(k);
         end
      end
   end

   // Run length: grows on hits up to req, drops on misses, holds across invalid gaps
   always_comb begin
      req   = (req_consec == '0) ? REQ_W'(1) : req_consec;
      run_d = run_q;
      if (in_valid) begin
         if (any_hit) begin
            run_d = (run_q >= req) ? req : run_q + REQ_W'(1);
         end else begin
            run_d = '0;
         end
      end
      fire = in_valid && any_hit && (run_d >= req);
   end

   // State and run length registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         run_q   <= '0;
      end else begin
         state_q <= state_d;
         run_q   <= run_d;
      end
   end

   // Next state tracks the updated run length; only valid words move the FSM
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (in_valid && any_hit) begin
               state_d = (run_d >= req) ? LOCK : RUN;
            end
         end
         RUN, LOCK: begin
            if (in_valid) begin
               if (!any_hit) begin
                  state_d = IDLE;
               end else begin
                  state_d = (run_d >= req) ? LOCK : RUN;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State exposed directly as the run_state encoding
   always_comb begin
      run_state = state_q;
   end

   // Qualified match pulse, held index, sticky flag and saturating count; a match beats clr
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         match     <= 1'b0;
         match_idx <= '0;
         set       <= 1'b0;
         hit_count <= '0;
      end else begin
         match <= fire;
         if (fire) begin
            match_idx <= hit_idx;
            set       <= 1'b1;
            if (clr) begin
               hit_count <= CNT_W'(1);
            end else if (hit_count != '1) begin
               hit_count <= hit_count + CNT_W'(1);
            end
         end else if (clr) begin
            set       <= 1'b0;
            hit_count <= '0;
         end
      end
   end

endmodule

// File: tb/tb_pattern_match_engine.sv
// tb/tb_pattern_match_engine.sv - vector table, corner sequences and randomized model check
module tb_pattern_match_engine;

   localparam int WIDTH   = 19;
   localparam int NUM_PAT = 2;
   localparam int CNT_W   = 2;
   localparam int REQ_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst;
   logic              cfg_we;
   logic [0:0]        cfg_idx;
   logic [WIDTH-1:0]  cfg_pattern;
   logic [WIDTH-1:0]  cfg_care;
   logic              cfg_en;
   logic              in_valid;
   logic [WIDTH-1:0]  in_word;
   logic [REQ_W-1:0]  req_consec;
   logic              clr;
   logic              match;
   logic [0:0]        match_idx;
   logic              set;
   logic [CNT_W-1:0]  hit_count;
   logic [1:0]        run_state;

   int total = 0;
   int bad   = 0;

   pattern_match_engine #(
      .WIDTH(WIDTH), .NUM_PAT(NUM_PAT), .CNT_W(CNT_W), .REQ_W(REQ_W)
   ) dut (
      .clk(clk), .rst(rst),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pattern(cfg_pattern),
      .cfg_care(cfg_care), .cfg_en(cfg_en),
      .in_valid(in_valid), .in_word(in_word), .req_consec(req_consec), .clr(clr),
      .match(match), .match_idx(match_idx), .set(set),
      .hit_count(hit_count), .run_state(run_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic             we;
      logic [0:0]       idx;
      logic [WIDTH-1:0] pat;
      logic [WIDTH-1:0] care;
      logic             en;
      logic             valid;
      logic [WIDTH-1:0] word;
      logic [REQ_W-1:0] req;
      logic             clr;
      logic             m;
      logic [0:0]       mi;
      logic             s;
      logic [CNT_W-1:0] cnt;
      logic [1:0]       st;
   } vec_t;

   vec_t tbl [30];

   // behavioural reference state
   logic [WIDTH-1:0] m_pat  [NUM_PAT];
   logic [WIDTH-1:0] m_care [NUM_PAT];
   bit               m_en   [NUM_PAT];
   int               m_run, m_state, m_idx, m_cnt;
   bit               m_match, m_set;

   function automatic vec_t v(input logic we, input logic [0:0] idx, input logic [WIDTH-1:0] pat,
                              input logic [WIDTH-1:0] care, input logic en, input logic valid,
                              input logic [WIDTH-1:0] word, input logic [REQ_W-1:0] req,
                              input logic c, input logic m, input logic [0:0] mi, input logic s,
                              input logic [CNT_W-1:0] cnt, input logic [1:0] st);
      vec_t r;
      r.we = we; r.idx = idx; r.pat = pat; r.care = care; r.en = en;
      r.valid = valid; r.word = word; r.req = req; r.clr = c;
      r.m = m; r.mi = mi; r.s = s; r.cnt = cnt; r.st = st;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < NUM_PAT; k++) begin
         m_pat[k] = '0; m_care[k] = '0; m_en[k] = 0;
      end
      m_run = 0; m_state = 0; m_idx = 0; m_cnt = 0; m_match = 0; m_set = 0;
   endtask

   task automatic model_edge(input vec_t x);
      int  r;
      bit  hit;
      int  hidx;
      r    = (x.req == 0) ? 1 : int'(x.req);
      hit  = 0;
      hidx = 0;
      for (int k = 0; k < NUM_PAT; k++) begin
         if (!hit && m_en[k] && (((x.word ^ m_pat[k]) & m_care[k]) == 0)) begin
            hit = 1; hidx = k;
         end
      end
      m_match = 0;
      if (x.valid) begin
         if (hit) begin
            m_run = (m_run + 1 > r) ? r : m_run + 1;
            if (m_run >= r) begin
               m_match = 1; m_idx = hidx;
            end
         end else begin
            m_run = 0;
         end
         m_state = (m_run == 0) ? 0 : ((m_run < r) ? 1 : 2);
      end
      if (m_match) begin
         m_set = 1;
         m_cnt = x.clr ? 1 : ((m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX);
      end else if (x.clr) begin
         m_set = 0; m_cnt = 0;
      end
      if (x.we && (int'(x.idx) < NUM_PAT)) begin
         m_pat[x.idx] = x.pat; m_care[x.idx] = x.care; m_en[x.idx] = x.en;
      end
   endtask

   // drive at negedge, clock once, update the model, compare at the following negedge
   task automatic step(input vec_t x);
      cfg_we = x.we; cfg_idx = x.idx; cfg_pattern = x.pat; cfg_care = x.care; cfg_en = x.en;
      in_valid = x.valid; in_word = x.word; req_consec = x.req; clr = x.clr;
      @(posedge clk);
      model_edge(x);
      @(negedge clk);
   endtask

   task automatic chk_model(input string tag);
      chk({tag, "_match"}, match, m_match);
      chk({tag, "_idx"}, match_idx, m_idx);
      chk({tag, "_set"}, set, m_set);
      chk({tag, "_cnt"}, hit_count, m_cnt);
      chk({tag, "_state"}, run_state, m_state);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_match"}, match, 0);
      chk({tag, "_idx"}, match_idx, 0);
      chk({tag, "_set"}, set, 0);
      chk({tag, "_cnt"}, hit_count, 0);
      chk({tag, "_state"}, run_state, 0);
   endtask

   initial begin
      vec_t x;
      tbl[0]  = v(0,0,0,0,0,                  1,19'h12345,1,0, 0,0,0,0,0);
      tbl[1]  = v(1,0,19'h12345,19'h7FFFF,1,  0,0,1,0,         0,0,0,0,0);
      tbl[2]  = v(1,1,19'h7FFFF,19'h7FFFF,1,  0,0,1,0,         0,0,0,0,0);
      tbl[3]  = v(0,0,0,0,0,                  1,19'h12345,1,0, 1,0,1,1,2);
      tbl[4]  = v(0,0,0,0,0,                  1,19'h7FFFF,1,0, 1,1,1,2,2);
      tbl[5]  = v(0,0,0,0,0,                  1,19'h00000,1,0, 0,1,1,2,0);
      tbl[6]  = v(1,0,19'h12345,19'h7FFF0,1,  0,0,1,0,         0,1,1,2,0);
      tbl[7]  = v(0,0,0,0,0,                  1,19'h12349,1,0, 1,0,1,3,2);
      tbl[8]  = v(0,0,0,0,0,                  1,19'h12355,1,0, 0,0,1,3,0);
      tbl[9]  = v(0,0,0,0,0,                  1,19'h12345,1,0, 1,0,1,3,2);
      tbl[10] = v(0,0,0,0,0,                  1,19'h12345,1,0, 1,0,1,3,2);
      tbl[11] = v(0,0,0,0,0,                  0,0,1,1,         0,0,0,0,2);
      tbl[12] = v(0,0,0,0,0,                  1,19'h12345,1,1, 1,0,1,1,2);
      tbl[13] = v(1,0,0,0,1,                  0,0,1,0,         0,0,1,1,2);
      tbl[14] = v(1,1,0,0,1,                  0,0,1,0,         0,0,1,1,2);
      tbl[15] = v(0,0,0,0,0,                  1,19'h55555,1,0, 1,0,1,2,2);
      tbl[16] = v(1,0,19'h12345,19'h7FFFF,0,  1,19'h12345,1,0, 1,0,1,3,2);
      tbl[17] = v(0,0,0,0,0,                  1,19'h12345,1,0, 1,1,1,3,2);
      tbl[18] = v(1,1,19'h7FFFF,19'h7FFFF,0,  0,0,1,0,         0,1,1,3,2);
      tbl[19] = v(0,0,0,0,0,                  1,19'h12345,1,0, 0,1,1,3,0);
      tbl[20] = v(1,0,19'h12345,19'h7FFFF,1,  0,0,3,1,         0,1,0,0,0);
      tbl[21] = v(0,0,0,0,0,                  1,19'h12345,3,0, 0,1,0,0,1);
      tbl[22] = v(0,0,0,0,0,                  1,19'h12345,3,0, 0,1,0,0,1);
      tbl[23] = v(0,0,0,0,0,                  0,0,3,0,         0,1,0,0,1);
      tbl[24] = v(0,0,0,0,0,                  1,19'h12345,3,0, 1,0,1,1,2);
      tbl[25] = v(0,0,0,0,0,                  1,19'h12345,3,0, 1,0,1,2,2);
      tbl[26] = v(0,0,0,0,0,                  1,19'h00000,3,0, 0,0,1,2,0);
      tbl[27] = v(0,0,0,0,0,                  1,19'h12345,3,0, 0,0,1,2,1);
      tbl[28] = v(0,0,0,0,0,                  1,19'h12345,1,0, 1,0,1,3,2);
      tbl[29] = v(0,0,0,0,0,                  1,19'h12345,0,0, 1,0,1,3,2);

      rst = 1'b1;
      cfg_we = 0; cfg_idx = 0; cfg_pattern = 0; cfg_care = 0; cfg_en = 0;
      in_valid = 0; in_word = 0; req_consec = 1; clr = 0;
      model_reset();
      repeat (2) @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;

      for (int i = 0; i < 30; i++) begin
         step(tbl[i]);
         chk($sformatf("vec%0d_match", i), match, tbl[i].m);
         chk($sformatf("vec%0d_idx", i), match_idx, tbl[i].mi);
         chk($sformatf("vec%0d_set", i), set, tbl[i].s);
         chk($sformatf("vec%0d_cnt", i), hit_count, tbl[i].cnt);
         chk($sformatf("vec%0d_state", i), run_state, tbl[i].st);
      end

      // asynchronous reset between edges while locked with set high
      #2 rst = 1'b1;
      #1 chk_zero("async_rst");
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      step(v(0,0,0,0,0, 1,19'h12345,1,0, 0,0,0,0,0));
      chk_zero("post_rst");

      // randomized traffic against the reference model
      for (int i = 0; i < 400; i++) begin
         x = v(0,0,0,0,0, 0,0,0,0, 0,0,0,0,0);
         x.we  = ($urandom_range(0, 9) == 0);
         x.idx = 1'($urandom_range(0, 1));
         x.pat = 19'($urandom);
         case ($urandom_range(0, 2))
            0: x.care = '1;
            1: x.care = '0;
            default: x.care = 19'($urandom);
         endcase
         x.en    = ($urandom_range(0, 3) != 0);
         x.valid = ($urandom_range(0, 4) != 0);
         if ($urandom_range(0, 3) == 0) x.word = 19'($urandom);
         else x.word = m_pat[$urandom_range(0, 1)] ^ (($urandom_range(0, 1) == 0) ? 19'h0 : 19'(1 << $urandom_range(0, 18)));
         x.req = 4'($urandom_range(0, 3));
         x.clr = ($urandom_range(0, 19) == 0);
         step(x);
         chk_model($sformatf("rnd%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
